sram_param: RTL and testbench

- Parametrised single-port synchronous SRAM with valid/ready request handshake, byte-lane write strobes, configurable wait states and out-of-range address error reporting.
- Next-generation replacement for the fixed 2048x16 RAM.
- Sits behind a bus master that issues one request at a time and holds it until acknowledged.

---
 rtl/sram_pkg.sv | 17 +
 rtl/sram_if.sv | 27 ++
 rtl/sram_array.sv | 33 +++
 rtl/sram_param.sv | 200 ++++++++++++++++++++
 tb/tb_sram_param.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the parametrised SRAM.
// State encoding, wait-counter width and error flag values.
package sram_pkg;

  localparam int CNT_W = 4;

  localparam logic ERR_NONE  = 1'b0;
  localparam logic ERR_RANGE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    CLEAR
  } state_t;

endpackage

// File: rtl/sram_if.sv
// Request/response bundle between a bus master and sram_param.
// Master drives the request, slave returns ready/error/rdata.
interface sram_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                write;
  logic                valid;
  logic [DATA_W-1:0]   rdata;
  logic                error;
  logic                ready;

  modport master (
    output addr, wdata, wstrb, write, valid,
    input  rdata, error, ready
  );

  modport slave (
    input  addr, wdata, wstrb, write, valid,
    output rdata, error, ready
  );

endinterface

// File: rtl/sram_array.sv
// DEPTH x DATA_W storage, per-byte write enable, registered read.
// No reset: contents and read register power up undefined.
module sram_array
  import sram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2048,
  parameter int IDX_W  = 11
) (
  input  logic                clk,
  input  logic                re,
  input  logic [DATA_W/8-1:0] we,
  input  logic [IDX_W-1:0]    addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   q
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (we[k]) begin
        mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
    if (re) begin
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/sram_param.sv
// Single-port SRAM with valid/ready handshake, wait states, range check.
// Define SRAM_CLEAR_EN to zero the array after every reset release.
module sram_param
  import sram_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 2048,
  parameter int WAIT_STATES = 1
) (
  input logic   clk,
  input logic   rst_n,
  sram_if.slave bus
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] LAST =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] CLR_LAST = IDX_W'(DEPTH - 1);

`ifdef SRAM_CLEAR_EN
  localparam state_t RST_ST = CLEAR;
`else
  localparam state_t RST_ST = IDLE;
`endif

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;

  logic              capture;
  logic              go_resp;

  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [NB-1:0]     cap_wstrb;
  logic              cap_write;

  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [NB-1:0]     acc_wstrb;
  logic              acc_write;
  logic              in_range;

  logic [IDX_W-1:0]  arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [NB-1:0]     arr_we;
  logic              arr_re;
  logic [DATA_W-1:0] arr_q;

  logic              rd_hit;
  logic              err_q;

  logic [IDX_W-1:0]  clr_addr;
  logic              clr_busy;
  logic              clr_done;

`ifdef SRAM_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_addr <= '0;
    end else if (state == CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
    end
  end
`else
  assign clr_addr = '0;
`endif

  assign clr_busy = (state == CLEAR);
  assign clr_done = (clr_addr == CLR_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_ST;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    go_resp  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.valid) begin
          capture = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nx = RESP;
            go_resp  = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == LAST) begin
          state_nx = RESP;
          go_resp  = 1'b1;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      CLEAR: begin
        if (clr_done) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // With zero wait states the access happens on the capture edge itself.
  assign acc_addr  = capture ? bus.addr  : cap_addr;
  assign acc_wdata = capture ? bus.wdata : cap_wdata;
  assign acc_wstrb = capture ? bus.wstrb : cap_wstrb;
  assign acc_write = capture ? bus.write : cap_write;
  assign in_range  = ({1'b0, acc_addr} < LIMIT);

  always_comb begin
    arr_addr  = acc_addr[IDX_W-1:0];
    arr_wdata = acc_wdata;
    arr_we    = '0;
    arr_re    = 1'b0;
    unique case (1'b1)
      clr_busy: begin
        arr_addr  = clr_addr;
        arr_wdata = '0;
        arr_we    = '1;
      end
      go_resp: begin
        if (in_range) begin
          arr_we = acc_write ? acc_wstrb : '0;
          arr_re = !acc_write;
        end
      end
      default: begin
      end
    endcase
  end

  sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .re    (arr_re),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .q     (arr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_wstrb <= '0;
      cap_write <= 1'b0;
      rd_hit    <= 1'b0;
      err_q     <= ERR_NONE;
    end else begin
      if (capture) begin
        cap_addr  <= bus.addr;
        cap_wdata <= bus.wdata;
        cap_wstrb <= bus.wstrb;
        cap_write <= bus.write;
      end
      err_q <= ERR_NONE;
      if (go_resp) begin
        err_q <= in_range ? ERR_NONE : ERR_RANGE;
        if (!acc_write) begin
          rd_hit <= in_range;
        end
      end
    end
  end

  // rd_hit masks the read register so reset and range misses show zero.
  assign bus.rdata = rd_hit ? arr_q : '0;
  assign bus.error = err_q;
  assign bus.ready = (state == RESP);

endmodule

// File: tb/tb_sram_param.sv
// Directed bench for sram_param (16-bit, 2048 words, one wait state).
// Checks reset, fill/readback, strobes, range errors, reset mid-write.
module tb_sram_param;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int DEPTH = 2048;
  localparam int WS = 1;

  logic clk = 1'b1;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  sram_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_param #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .DEPTH       (DEPTH),
    .WAIT_STATES (WS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [AW-1:0] a,
                      input logic [DW-1:0] d,
                      input logic [1:0]    s,
                      input logic          w,
                      input logic          exp_err,
                      input logic          chk_rd,
                      input logic [DW-1:0] exp_rd,
                      input string         tag);
    int n;
    n = 0;
    bus.addr  = a;
    bus.wdata = d;
    bus.wstrb = s;
    bus.write = w;
    bus.valid = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.ready && n < 10);
    chk({tag, " lat"}, n, WS + 1);
    chk({tag, " err"}, bus.error, exp_err);
    if (chk_rd) chk({tag, " rdata"}, bus.rdata, exp_rd);
    bus.valid = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " pulse"}, {bus.ready, bus.error}, 2'b00);
  endtask

  initial begin
    logic seen;
    int n;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.wstrb = '0;
    bus.write = 1'b0;
    bus.valid = 1'b0;
    rst_n = 1'b0;

`ifdef SRAM_CLEAR_EN
    bus.addr  = 16'd100;
    bus.valid = 1'b1;
    #15 rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.ready && n < 3000);
    chk("clear lat", n, DEPTH + 2);
    chk("clear rdata", bus.rdata, 16'h0000);
    chk("clear err", bus.error, 1'b0);
    bus.valid = 1'b0;
`else
    #12;
    chk("rst rdata", bus.rdata, 16'h0000);
    chk("rst ready", bus.ready, 1'b0);
    chk("rst error", bus.error, 1'b0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < DEPTH; i++)
      xfer(AW'(i), DW'(i + 1), 2'b11, 1'b1, 1'b0, 1'b0, '0,
           $sformatf("wr%0d", i));
    for (int i = 0; i < DEPTH; i++)
      xfer(AW'(i), '0, 2'b00, 1'b0, 1'b0, 1'b1, DW'(i + 1),
           $sformatf("rd%0d", i));

    xfer(16'd5, 16'hAAAA, 2'b11, 1'b1, 1'b0, 1'b0, '0, "strb full");
    xfer(16'd5, 16'h1234, 2'b01, 1'b1, 1'b0, 1'b0, '0, "strb low");
    xfer(16'd5, '0, 2'b00, 1'b0, 1'b0, 1'b1, 16'hAA34, "strb rd");

    xfer(16'd6, 16'h0000, 2'b00, 1'b1, 1'b0, 1'b1, 16'hAA34, "nostrb wr");
    xfer(16'd6, '0, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0007, "nostrb rd");

    xfer(16'd2048, 16'hFFFF, 2'b11, 1'b1, 1'b1, 1'b1, 16'h0007, "oor wr");
    xfer(16'd2048, '0, 2'b00, 1'b0, 1'b1, 1'b1, 16'h0000, "oor rd");
    xfer(16'hFFFF, '0, 2'b00, 1'b0, 1'b1, 1'b1, 16'h0000, "oor top");
    xfer(16'd0, '0, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0001, "rd0");

    bus.addr  = 16'd7;
    bus.wdata = 16'h5555;
    bus.wstrb = 2'b11;
    bus.write = 1'b1;
    bus.valid = 1'b1;
    @(posedge clk);
    #1;
    chk("mid wait ready", bus.ready, 1'b0);
    rst_n = 1'b0;
    bus.valid = 1'b0;
    #1;
    chk("mid rst ready", bus.ready, 1'b0);
    chk("mid rst rdata", bus.rdata, 16'h0000);
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      seen |= bus.ready;
    end
    #2 rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      seen |= bus.ready;
    end
    chk("mid no ready", seen, 1'b0);
    xfer(16'd7, '0, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0008, "mid rd7");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
